sr_key_driver: RTL and testbench

- Front-end stage that drives the s/r/c inputs of the level-sensitive SR latch from two raw DE10 pushbuttons.
- Synchronizes and debounces both keys, then turns each accepted press into a fixed-width set or reset pulse.
- Arbitrates simultaneous presses, ignores new presses until the keys are released, and counts accepted commands.

---
 rtl/sr_key_pkg.sv | 24 ++
 rtl/sr_key_driver_if.sv | 26 ++
 rtl/sr_key_driver_debounce.sv | 59 +++++
 rtl/sr_key_driver.sv | 137 +++++++++++++
 tb/tb_sr_key_driver.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_key_pkg.sv
// Shared types and defaults for the pushbutton front end that drives the SR latch.
package sr_key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        RST_PULSE = 2'd2,
        WAIT_REL  = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_PULSE_CYCLES    = 4;
    localparam int DEF_CNT_W           = 8;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    function automatic int debounce_cnt_w(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

    function automatic int pulse_cnt_w(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sr_key_driver_if.sv
// Board-side key inputs and latch-side drive outputs of sr_key_driver.
interface sr_key_driver_if
    import sr_key_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             key_set_n;
    logic             key_rst_n;
    logic             en;
    logic             s;
    logic             r;
    logic             c;
    logic             busy;
    logic [CNT_W-1:0] cmd_cnt;
    logic             err;

    modport master (
        output key_set_n, key_rst_n, en,
        input  s, r, c, busy, cmd_cnt, err
    );

    modport slave (
        input  key_set_n, key_rst_n, en,
        output s, r, c, busy, cmd_cnt, err
    );
endinterface

// File: rtl/sr_key_driver_debounce.sv
// One pushbutton: 2-flop synchronizer, level debounce and a one-cycle press strobe.
module key_debounce
    import sr_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int            CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          pressed;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;

    // Synchronizer idles at "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = ~sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (pressed == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                level_q <= pressed;
                // Strobe rides with the 0->1 toggle, releases give none.
                press_q <= pressed;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/sr_key_driver.sv
// Turns debounced set/reset pushbuttons into fixed-width s/r/c pulses for the SR latch.
// Define SR_KEY_CONFLICT_EN to flag simultaneous keys as an error instead of reset-priority.
module sr_key_driver
    import sr_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_key_driver_if.slave    bus
);
    localparam int            PW         = pulse_cnt_w(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

    logic             set_lvl;
    logic             set_evt;
    logic             rst_lvl;
    logic             rst_evt;
    logic             conflict;

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    pcnt_q;
    logic [PW-1:0]    pcnt_d;
    logic             cnt_inc;
    logic             s_q;
    logic             r_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_set_db (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_set_n),
        .level (set_lvl),
        .press (set_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rst_db (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_rst_n),
        .level (rst_lvl),
        .press (rst_evt)
    );

`ifdef SR_KEY_CONFLICT_EN
    assign conflict = (set_lvl & rst_lvl) | (set_evt & rst_evt);
`else
    assign conflict = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (conflict) begin
                    state_d = WAIT_REL;
                end else if (bus.en && rst_evt) begin
                    state_d = RST_PULSE;
                    pcnt_d  = PULSE_LOAD;
                    cnt_inc = 1'b1;
                end else if (bus.en && set_evt) begin
                    state_d = SET_PULSE;
                    pcnt_d  = PULSE_LOAD;
                    cnt_inc = 1'b1;
                end
            end
            SET_PULSE, RST_PULSE: begin
                if (pcnt_q == '0) begin
                    state_d = WAIT_REL;
                end else begin
                    pcnt_d = pcnt_q - PW'(1);
                end
            end
            WAIT_REL: begin
                // Holding either key keeps the driver deaf to further presses.
                if (!set_lvl && !rst_lvl) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive outputs come from the next state so they line up with state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            s_q     <= (state_d == SET_PULSE);
            r_q     <= (state_d == RST_PULSE);
            c_q     <= (state_d == SET_PULSE) || (state_d == RST_PULSE);
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef SR_KEY_CONFLICT_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && conflict) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.s       = s_q;
    assign bus.r       = r_q;
    assign bus.c       = c_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.cmd_cnt = cnt_q;

endmodule

// File: tb/tb_sr_key_driver.sv
// Directed bench for sr_key_driver with DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, CNT_W=8.
module tb_sr_key_driver;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    logic [7:0] exp_cnt;
    logic       exp_err;

    sr_key_driver_if #(.CNT_W(8)) bus_if ();

    sr_key_driver #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (3),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp_cnt  = 8'd0;
`ifdef SR_KEY_CONFLICT_EN
        exp_err  = 1'b1;
`else
        exp_err  = 1'b0;
`endif
        rst_n            = 1'b0;
        bus_if.key_set_n = 1'b1;
        bus_if.key_rst_n = 1'b1;
        bus_if.en        = 1'b1;

        // Reset state
        tick(3);
        chk1("rst_s", bus_if.s, 1'b0);
        chk1("rst_r", bus_if.r, 1'b0);
        chk1("rst_c", bus_if.c, 1'b0);
        chk1("rst_busy", bus_if.busy, 1'b0);
        chk8("rst_cnt", bus_if.cmd_cnt, 8'd0);
        chk1("rst_err", bus_if.err, 1'b0);

        // Key pressed during reset: pulse only 2+4+1 cycles after release
        bus_if.key_set_n = 1'b0;
        tick(2);
        chk1("inrst_s", bus_if.s, 1'b0);
        rst_n = 1'b1;
        tick(6);
        chk1("rel6_s", bus_if.s, 1'b0);
        chk1("rel6_busy", bus_if.busy, 1'b0);
        tick(1);
        exp_cnt = exp_cnt + 8'd1;
        chk1("rel7_s", bus_if.s, 1'b1);
        chk1("rel7_c", bus_if.c, 1'b1);
        chk1("rel7_r", bus_if.r, 1'b0);
        chk1("rel7_busy", bus_if.busy, 1'b1);
        chk8("rel7_cnt", bus_if.cmd_cnt, exp_cnt);
        tick(2);
        chk1("rel9_s", bus_if.s, 1'b1);
        tick(1);
        chk1("rel10_s", bus_if.s, 1'b0);
        chk1("rel10_c", bus_if.c, 1'b0);
        chk1("rel10_busy", bus_if.busy, 1'b1);
        bus_if.key_set_n = 1'b1;
        tick(6);
        chk1("keyup6_busy", bus_if.busy, 1'b1);
        tick(1);
        chk1("keyup7_busy", bus_if.busy, 1'b0);

        // Clean set press held 20 cycles
        bus_if.key_set_n = 1'b0;
        tick(6);
        chk1("set6_s", bus_if.s, 1'b0);
        tick(1);
        exp_cnt = exp_cnt + 8'd1;
        chk1("set7_s", bus_if.s, 1'b1);
        chk1("set7_c", bus_if.c, 1'b1);
        tick(2);
        chk1("set9_s", bus_if.s, 1'b1);
        tick(1);
        chk1("set10_s", bus_if.s, 1'b0);
        chk8("set_cnt", bus_if.cmd_cnt, exp_cnt);
        tick(10);
        chk1("set20_busy", bus_if.busy, 1'b1);
        bus_if.key_set_n = 1'b1;
        tick(6);
        chk1("setup6_busy", bus_if.busy, 1'b1);
        tick(1);
        chk1("setup7_busy", bus_if.busy, 1'b0);

        // Bouncing reset key, 2-cycle glitches for 12 cycles, then held
        for (int i = 0; i < 6; i++) begin
            bus_if.key_rst_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        bus_if.key_rst_n = 1'b0;
        chk1("bnc_r", bus_if.r, 1'b0);
        chk1("bnc_busy", bus_if.busy, 1'b0);
        tick(6);
        chk1("bnc6_r", bus_if.r, 1'b0);
        tick(1);
        exp_cnt = exp_cnt + 8'd1;
        chk1("bnc7_r", bus_if.r, 1'b1);
        chk1("bnc7_c", bus_if.c, 1'b1);
        chk1("bnc7_s", bus_if.s, 1'b0);
        tick(2);
        chk1("bnc9_r", bus_if.r, 1'b1);
        tick(1);
        chk1("bnc10_r", bus_if.r, 1'b0);
        chk8("bnc_cnt", bus_if.cmd_cnt, exp_cnt);
        bus_if.key_rst_n = 1'b1;
        tick(7);
        chk1("bncup_busy", bus_if.busy, 1'b0);

        // Simultaneous press
        bus_if.key_set_n = 1'b0;
        bus_if.key_rst_n = 1'b0;
        tick(7);
`ifdef SR_KEY_CONFLICT_EN
        chk1("sim_r", bus_if.r, 1'b0);
        chk1("sim_s", bus_if.s, 1'b0);
        chk1("sim_c", bus_if.c, 1'b0);
        chk1("sim_busy", bus_if.busy, 1'b1);
        chk1("sim_err", bus_if.err, 1'b1);
        chk8("sim_cnt", bus_if.cmd_cnt, exp_cnt);
`else
        exp_cnt = exp_cnt + 8'd1;
        chk1("sim_r", bus_if.r, 1'b1);
        chk1("sim_s", bus_if.s, 1'b0);
        chk1("sim_c", bus_if.c, 1'b1);
        chk1("sim_err", bus_if.err, 1'b0);
        chk8("sim_cnt", bus_if.cmd_cnt, exp_cnt);
        tick(2);
        chk1("sim9_r", bus_if.r, 1'b1);
        chk1("sim9_s", bus_if.s, 1'b0);
        tick(1);
        chk1("sim10_r", bus_if.r, 1'b0);
`endif
        bus_if.key_set_n = 1'b1;
        bus_if.key_rst_n = 1'b1;
        tick(7);
        chk1("simup_busy", bus_if.busy, 1'b0);
        chk1("simup_err", bus_if.err, exp_err);

        // Presses while busy are dropped
        bus_if.key_set_n = 1'b0;
        tick(7);
        exp_cnt = exp_cnt + 8'd1;
        chk1("bsy7_s", bus_if.s, 1'b1);
        bus_if.key_rst_n = 1'b0;
        tick(3);
        chk1("bsy10_s", bus_if.s, 1'b0);
        bus_if.key_set_n = 1'b1;
        tick(8);
        chk1("bsy18_busy", bus_if.busy, 1'b1);
        chk1("bsy18_r", bus_if.r, 1'b0);
        bus_if.key_set_n = 1'b0;
        tick(10);
        chk1("bsy28_s", bus_if.s, 1'b0);
        chk1("bsy28_r", bus_if.r, 1'b0);
        chk1("bsy28_busy", bus_if.busy, 1'b1);
        chk8("bsy_cnt", bus_if.cmd_cnt, exp_cnt);
        bus_if.key_set_n = 1'b1;
        bus_if.key_rst_n = 1'b1;
        tick(7);
        chk1("bsyup_busy", bus_if.busy, 1'b0);

        // Press with en=0 is discarded
        bus_if.en        = 1'b0;
        bus_if.key_set_n = 1'b0;
        tick(10);
        chk1("en0_s", bus_if.s, 1'b0);
        chk1("en0_busy", bus_if.busy, 1'b0);
        chk8("en0_cnt", bus_if.cmd_cnt, exp_cnt);
        bus_if.key_set_n = 1'b1;
        tick(7);
        bus_if.en = 1'b1;

        // Accepted-command counter wraps from 255 to 0
        while (exp_cnt != 8'hFF) begin
            bus_if.key_set_n = 1'b0;
            tick(10);
            bus_if.key_set_n = 1'b1;
            tick(7);
            exp_cnt = exp_cnt + 8'd1;
        end
        chk8("cnt_ff", bus_if.cmd_cnt, 8'hFF);
        bus_if.key_set_n = 1'b0;
        tick(10);
        bus_if.key_set_n = 1'b1;
        tick(7);
        exp_cnt = exp_cnt + 8'd1;
        chk8("cnt_wrap", bus_if.cmd_cnt, 8'd0);
        chk1("wrap_err", bus_if.err, exp_err);

        // Reset during the second pulse cycle cuts the pulse at once
        bus_if.key_set_n = 1'b0;
        tick(7);
        chk1("mid7_s", bus_if.s, 1'b1);
        tick(1);
        chk1("mid8_s", bus_if.s, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("midrst_s", bus_if.s, 1'b0);
        chk1("midrst_c", bus_if.c, 1'b0);
        chk1("midrst_busy", bus_if.busy, 1'b0);
        chk8("midrst_cnt", bus_if.cmd_cnt, 8'd0);
        chk1("midrst_err", bus_if.err, 1'b0);
        bus_if.key_set_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk1("post_s", bus_if.s, 1'b0);
        chk1("post_busy", bus_if.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
